// File: rtl/q4_equiv_sweeper.sv
// Self-running equivalence sweeper: walks every input vector onto the f/g pair,
// holds it DWELL cycles, compares in the last one and reports mismatch statistics.
module q4_equiv_sweeper #(
  parameter int N_IN  = 5,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] x,
  input  logic            f_in,
  input  logic            g_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  // DWELL=1 still needs a 1-bit counter; it simply stays at zero.
  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST     = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] X_MAX  = '1;
  localparam logic [N_IN-1:0] X_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   MC_ONE = (N_IN + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] dwell_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      dwell_cnt        <= '0;
      x                <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state            <= S_RUN;
            dwell_cnt        <= '0;
            x                <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (dwell_cnt != LAST) begin
            dwell_cnt <= dwell_cnt + CNT_ONE;
          end else begin
            if (f_in != g_in) begin
              mismatch_cnt <= mismatch_cnt + MC_ONE;
              if (!first_fail_valid) begin
                first_fail_vec   <= x;
                first_fail_valid <= 1'b1;
              end
            end
            // Terminate at all-ones rather than wrapping back to zero.
            if (x != X_MAX) begin
              x         <= x + X_ONE;
              dwell_cnt <= '0;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_q4_equiv_sweeper.sv
// Scoreboard bench: stimulus pushes truth-table-derived expectations, monitors
// pop them when done rises and also track the vector walk while busy.
module tb_q4_equiv_sweeper;
  localparam int N  = 5;
  localparam int NV = 32;
  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start0, busy0, done0, pass0, ffval0, f0, g0;
  logic [N-1:0] x0, ffv0;
  logic [N:0]   mc0;
  logic         start1, busy1, done1, pass1, ffval1, f1, g1;
  logic [N-1:0] x1, ffv1;
  logic [N:0]   mc1;
  logic [31:0]  ftt0, gtt0, ftt1, gtt1;

  assign f0 = ftt0[x0];
  assign g0 = gtt0[x0];
  assign f1 = ftt1[x1];
  assign g1 = gtt1[x1];

  q4_equiv_sweeper #(.N_IN(N), .DWELL(D0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .x(x0), .f_in(f0), .g_in(g0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mc0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0));

  q4_equiv_sweeper #(.N_IN(N), .DWELL(D1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .f_in(f1), .g_in(g1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mc1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1));

  typedef struct {
    int due;
    int cnt;
    int first;
    bit valid;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic dprev0, dprev1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a sweep result is just the set of differing truth-table rows.
  function automatic exp_t model(input logic [31:0] f, input logic [31:0] g);
    exp_t e;
    e.due = 0; e.cnt = 0; e.first = 0; e.valid = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (f[v] != g[v]) begin
        e.cnt++;
        if (!e.valid) begin
          e.first = v;
          e.valid = 1'b1;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy0) begin
        chk("pass0_while_busy", pass0, 0);
        chk("done0_while_busy", done0, 0);
        if (q0.size() > 0) chk("x0_walk", x0, (cyc - (q0[0].due - NV * D0)) / D0);
      end
      if (done0 && !dprev0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL done0_unexpected actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          chk("done0_cycle", cyc, e.due);
          chk("mismatch_cnt0", mc0, e.cnt);
          chk("first_fail_vec0", ffv0, e.first);
          chk("first_fail_valid0", ffval0, e.valid);
          chk("pass0", pass0, e.cnt == 0);
          chk("busy0_at_done", busy0, 0);
        end
      end
    end
    dprev0 <= done0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy1) begin
        chk("pass1_while_busy", pass1, 0);
        if (q1.size() > 0) chk("x1_walk", x1, (cyc - (q1[0].due - NV * D1)) / D1);
      end
      if (done1 && !dprev1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL done1_unexpected actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          chk("done1_cycle", cyc, e.due);
          chk("mismatch_cnt1", mc1, e.cnt);
          chk("first_fail_vec1", ffv1, e.first);
          chk("first_fail_valid1", ffval1, e.valid);
          chk("pass1", pass1, e.cnt == 0);
        end
      end
    end
    dprev1 <= done1;
  end

  task automatic issue(input int which, input logic [31:0] f, input logic [31:0] g);
    exp_t e;
    @(negedge clk);
    e = model(f, g);
    if (which == 0) begin
      ftt0 = f; gtt0 = g;
      e.due = cyc + 1 + NV * D0;
      q0.push_back(e);
      start0 = 1'b1;
    end else begin
      ftt1 = f; gtt1 = g;
      e.due = cyc + 1 + NV * D1;
      q1.push_back(e);
      start1 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    if (which == 0) begin
      chk("start_busy0", busy0, 1);
      chk("start_clears_done0", done0, 0);
      chk("start_clears_cnt0", mc0, 0);
      chk("start_clears_valid0", ffval0, 0);
      chk("start_x0", x0, 0);
    end else begin
      chk("start_busy1", busy1, 1);
      chk("start_x1", x1, 0);
    end
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    int lim = (which == 0) ? NV * D0 + 20 : NV * D1 + 20;
    while (((which == 0) ? !done0 : !done1) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      total++; bad++;
      $display("FAIL wait_done%0d timeout actual=%0d required<%0d", which, n, lim);
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_x"}, x0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_cnt"}, mc0, 0);
    chk({tag, "_ffv"}, ffv0, 0);
    chk({tag, "_ffvalid"}, ffval0, 0);
  endtask

  initial begin
    logic [31:0] eq, f, g;
    logic [4:0]  vv;
    int          due, n;
    start0 = 1'b0; start1 = 1'b0;
    ftt0 = '0; gtt0 = '0; ftt1 = '0; gtt1 = '0;
    for (int v = 0; v < NV; v++) begin
      vv = 5'(v);
      eq[v] = (vv[4] & vv[3]) | vv[0];
    end

    #12;
    chk_zero0("reset");
    chk("reset_busy1", busy1, 0);
    chk("reset_done1", done1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, eq, eq);                         wait_done(0);
    issue(0, eq, eq ^ (32'h1 << 22));         wait_done(0);
    issue(0, eq, ~eq);                        wait_done(0);
    for (int r = 0; r < 4; r++) begin
      f = $urandom;
      g = f ^ ($urandom & $urandom & $urandom);
      issue(0, f, g);                         wait_done(0);
    end
    f = $urandom;
    issue(0, f, f ^ (32'h1 << $urandom_range(31, 0))); wait_done(0);

    // Reset mid-sweep discards the sweep in flight.
    issue(0, eq, ~eq);
    n = 0;
    while (x0 != 5'd12 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_x12", x0, 12);
    #2 rst_n = 1'b0;
    q0.delete();
    #1 chk_zero0("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, eq, eq ^ 32'h0000_1000);         wait_done(0);

    // Starts during the sweep and on the final compare edge must be ignored.
    f = $urandom;
    g = f ^ $urandom;
    issue(0, f, g);
    due = q0[q0.size() - 1].due;
    repeat (9) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < due - 1) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_start_done", done0, 1);
    chk("late_start_busy", busy0, 0);
    chk("late_start_cnt", mc0, model(f, g).cnt);
    issue(0, eq, eq);                         wait_done(0);

    // One-cycle dwell instance.
    issue(1, eq, eq);                         wait_done(1);
    f = $urandom;
    issue(1, f, f ^ ($urandom & $urandom));   wait_done(1);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
